// File: rtl/uart_tx_framer.sv
// UART transmitter: valid/ready byte intake into a small FIFO, serialised as
// start, LSB-first data, optional parity and stop bit(s) at CLKS_PER_BIT clocks per bit.
module uart_tx_framer #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] head;
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]      level_q, level_d;
    logic                 push, pop;

    state_e               state_q, state_d;
    logic [CntW-1:0]      clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 txd_q, txd_d;
    logic                 bit_done;

    assign tx_ready   = (level_q != LvlW'(FIFO_DEPTH));
    assign push       = tx_valid && tx_ready;
    assign head       = mem_q[rd_ptr_q];
    assign fifo_level = level_q;
    assign busy       = (state_q != StIdle) || (level_q != '0);
    assign txd        = txd_q;
    assign bit_done   = (clk_cnt_q == CntW'(CLKS_PER_BIT - 1));

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LvlW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CntW'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        txd_d     = txd_q;
        pop       = 1'b0;

        unique case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                txd_d     = 1'b1;
                pop       = (level_q != '0);
            end
            StStart: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    txd_d     = shift_q[0];
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            txd_d   = parity_q;
                            state_d = StParity;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = StStop;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    txd_d     = 1'b1;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        txd_d     = 1'b1;
                        state_d   = StIdle;
                        // Chain straight into the next frame when data is waiting.
                        pop       = (level_q != '0);
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
            end
        endcase

        if (pop) begin
            shift_d   = head;
            parity_d  = (^head) ^ (PARITY_ODD != 0);
            txd_d     = 1'b0;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = StStart;
        end
    end

    // Storage has no reset; only occupied entries are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            level_q   <= level_d;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
        end
    end

endmodule
